// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types plus the state encoding of the I/D memory arbiter.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_memband;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2,
        ARB_RELEASE = 2'd3
    } lc3b_arb_state;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } lc3b_grant;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over an increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_count;

    // Count register: reset, clear, saturating increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= {WIDTH{1'b0}};
        end else if (clr) begin
            r_count <= {WIDTH{1'b0}};
        end else if (inc && (r_count != MAX_COUNT)) begin
            r_count <= r_count + WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one physical memory port between the I-cache and D-cache, one whole
// line transaction at a time, round-robin on contention, with grant statistics.
module cache_mem_arbiter
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  lc3b_word             icache_address,
    input  logic                 icache_read,
    output lc3b_memband          icache_rdata,
    output logic                 icache_resp,
    input  lc3b_word             dcache_address,
    input  logic                 dcache_read,
    input  logic                 dcache_write,
    input  lc3b_memband          dcache_wdata,
    output lc3b_memband          dcache_rdata,
    output logic                 dcache_resp,
    output lc3b_word             pmem_address,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output lc3b_memband          pmem_wdata,
    input  lc3b_memband          pmem_rdata,
    input  logic                 pmem_resp,
    input  logic                 stat_clear,
    output logic [CNT_WIDTH-1:0] stat_icount,
    output logic [CNT_WIDTH-1:0] stat_dcount
);

    lc3b_arb_state r_state;
    lc3b_arb_state w_next_state;
    lc3b_grant     r_last_grant;
    logic          w_i_req;
    logic          w_d_req;
    logic          w_grant_i;
    logic          w_grant_d;

    assign w_i_req = icache_read;
    assign w_d_req = dcache_read | dcache_write;

    // Data paths are pure wires; validity is qualified by the matching resp.
    assign pmem_wdata   = dcache_wdata;
    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;

    // State and round-robin history registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= GRANT_I;
        end else begin
            r_state <= w_next_state;
            if (w_grant_i) begin
                r_last_grant <= GRANT_I;
            end else if (w_grant_d) begin
                r_last_grant <= GRANT_D;
            end else begin
                r_last_grant <= r_last_grant;
            end
        end
    end

    // Next-state, arbitration and memory-port muxing.
    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        pmem_address = 16'h0000;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        icache_resp  = 1'b0;
        dcache_resp  = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                if (w_i_req && w_d_req) begin
                    // Contention: the side that did not win last time goes first.
                    if (r_last_grant == GRANT_I) begin
                        w_grant_d = 1'b1;
                    end else begin
                        w_grant_i = 1'b1;
                    end
                end else if (w_i_req) begin
                    w_grant_i = 1'b1;
                end else if (w_d_req) begin
                    w_grant_d = 1'b1;
                end else begin
                    w_grant_i = 1'b0;
                end

                if (w_grant_i) begin
                    w_next_state = ARB_SERVE_I;
                end else if (w_grant_d) begin
                    w_next_state = ARB_SERVE_D;
                end else begin
                    w_next_state = ARB_IDLE;
                end
            end

            ARB_SERVE_I: begin
                pmem_address = icache_address;
                pmem_read    = icache_read;
                if (pmem_resp) begin
                    icache_resp  = 1'b1;
                    w_next_state = ARB_RELEASE;
                end else begin
                    w_next_state = ARB_SERVE_I;
                end
            end

            ARB_SERVE_D: begin
                // Simultaneous read+write is illegal; the writeback takes it.
                pmem_address = dcache_address;
                pmem_read    = dcache_read & ~dcache_write;
                pmem_write   = dcache_write;
                if (pmem_resp) begin
                    dcache_resp  = 1'b1;
                    w_next_state = ARB_RELEASE;
                end else begin
                    w_next_state = ARB_SERVE_D;
                end
            end

            ARB_RELEASE: begin
                w_next_state = ARB_IDLE;
            end

            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_icount (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_grant_i),
        .clr   (stat_clear),
        .count (stat_icount)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_dcount (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_grant_d),
        .clr   (stat_clear),
        .count (stat_dcount)
    );

endmodule
